// File: rtl/pkt_tx_arbiter.sv
// pkt_tx_arbiter
// Shares one outbound transmitter link between NUM_REQ packet sources using
// bounded-burst round-robin arbitration. The winning packet is captured in a
// single registered output stage; a per-source pulse marks every acceptance
// so the counter bank can tally transmitted packets.
module pkt_tx_arbiter #(
    parameter int PACKET_BITS = 72,
    parameter int NUM_REQ     = 2,
    parameter int MAX_BURST   = 4
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [NUM_REQ*PACKET_BITS-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]             req_vld_in,
    output logic [NUM_REQ-1:0]             req_rdy_out,
    output logic [PACKET_BITS-1:0]         tx_data_out,
    output logic                           tx_vld_out,
    input  logic                           tx_rdy_in,
    input  logic                           arb_en_in,
    output logic [NUM_REQ-1:0]             tx_cnt_out
);

    // Owner index width and burst counter width (counter must hold MAX_BURST).
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    // After reset the owner points at the last index so the first search
    // starts at requester 0.
    localparam logic [OW-1:0] OWNER_RST = OW'(NUM_REQ - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);

    // Registered state.
    logic [PACKET_BITS-1:0] r_tx_data;
    logic                   r_tx_vld;
    logic [OW-1:0]          r_owner;
    logic [BW-1:0]          r_burst_cnt;

    // Combinational arbitration signals.
    logic                   w_slot_free;
    logic                   w_arb_go;
    logic [NUM_REQ-1:0]     w_elig;
    logic                   w_retain;
    logic                   w_found;
    logic [OW-1:0]          w_winner;
    logic [PACKET_BITS-1:0] w_win_data;
    logic [PACKET_BITS-1:0] w_req_data [NUM_REQ];

    // The output slot can take a new packet when empty or draining this cycle.
    assign w_slot_free = !r_tx_vld || tx_rdy_in;
    assign w_arb_go    = arb_en_in && w_slot_free;
    assign w_elig      = req_vld_in & {NUM_REQ{w_arb_go}};

    // Retain the current owner while its burst is open and it still has data.
    assign w_retain = (r_burst_cnt != '0) && (r_burst_cnt < BURST_MAX) && w_elig[r_owner];

    // Winner selection: retain, otherwise first eligible index after owner.
    // The loop runs from the farthest candidate down to the nearest so the
    // nearest eligible one is assigned last and therefore wins.
    always_comb begin
        int idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = r_owner;
        if (w_retain) begin
            w_found  = 1'b1;
            w_winner = r_owner;
        end else begin
            for (int k = NUM_REQ; k >= 1; k--) begin
                idx = (int'(r_owner) + k) % NUM_REQ;
                if (w_elig[idx]) begin
                    w_found  = 1'b1;
                    w_winner = OW'(idx);
                end
            end
        end
    end

    // Per-requester data slices, one-hot ready and acceptance pulses. Ready is
    // forced low while reset is held so nothing is handed over during reset.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_req_data[gi]  = req_data_in[gi*PACKET_BITS +: PACKET_BITS];
            assign req_rdy_out[gi] = resetn && w_found && (w_winner == OW'(gi));
            assign tx_cnt_out[gi]  = req_vld_in[gi] && req_rdy_out[gi];
        end
    endgenerate

    assign w_win_data = w_req_data[w_winner];

    // Output register: load on grant, clear valid when drained without refill.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tx_data <= '0;
            r_tx_vld  <= 1'b0;
        end else if (w_found) begin
            r_tx_data <= w_win_data;
            r_tx_vld  <= 1'b1;
        end else if (r_tx_vld && tx_rdy_in) begin
            r_tx_vld  <= 1'b0;
        end
    end

    // Owner and burst tracking; an idle free slot or disabled arbitration
    // breaks the burst while keeping the owner for round-robin fairness.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner     <= OWNER_RST;
            r_burst_cnt <= '0;
        end else if (w_found) begin
            if (w_winner == r_owner) begin
                if (r_burst_cnt < BURST_MAX) begin
                    r_burst_cnt <= r_burst_cnt + BURST_ONE;
                end
            end else begin
                r_owner     <= w_winner;
                r_burst_cnt <= BURST_ONE;
            end
        end else if (!arb_en_in || w_slot_free) begin
            r_burst_cnt <= '0;
        end
    end

    assign tx_data_out = r_tx_data;
    assign tx_vld_out  = r_tx_vld;

endmodule
